// File: rtl/fetch_pipe_if.sv
// Fetch-stage bundle: PC redirect controls in, imem address and IF/ID register contents out.
// The slave modport is the fetch stage; the master modport is its driver.
interface fetch_pipe_if #(
    parameter int unsigned N = 64
);
    logic         Stall_F;
    logic         PCSrc_F;
    logic [N-1:0] PCBranch_F;
    logic         EProc_F;
    logic [N-1:0] EVAddr_F;
    logic         ERet_F;
    logic [31:0]  imem_data_F;
    logic [N-1:0] imem_addr_F;
    logic [N-1:0] NextPC_F;
    logic [31:0]  instr_D;
    logic [N-1:0] pc_D;
    logic         valid_D;
    logic         misalign_F;
    logic [N-1:0] ELR_F;

    modport master (
        output Stall_F, PCSrc_F, PCBranch_F, EProc_F, EVAddr_F, ERet_F, imem_data_F,
        input  imem_addr_F, NextPC_F, instr_D, pc_D, valid_D, misalign_F, ELR_F
    );

    modport slave (
        input  Stall_F, PCSrc_F, PCBranch_F, EProc_F, EVAddr_F, ERet_F, imem_data_F,
        output imem_addr_F, NextPC_F, instr_D, pc_D, valid_D, misalign_F, ELR_F
    );
endinterface

// File: rtl/fetch_pipe.sv
// Instruction fetch stage: PC register with branch/exception redirect and IF/ID register.
// Define FETCH_PIPE_ELR_EN to add the exception link register and ERet_F return path.
module fetch_pipe #(
    parameter int unsigned  N        = 64,
    parameter int unsigned  INC      = 4,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic        clk,
    input  logic        reset,
    fetch_pipe_if.slave fif
);
    localparam logic [N-1:0] INC_N = N'(INC);

    logic [N-1:0] pc;
    logic [N-1:0] pc_seq;
    logic [N-1:0] pc_next;
    logic [N-1:0] elr;
    logic [31:0]  instr_q;
    logic [N-1:0] pc_d_q;
    logic         valid_q;
    logic         ret_take;
    logic         flush;

    assign pc_seq           = pc + INC_N;
    assign fif.imem_addr_F  = pc;
    assign fif.misalign_F   = (pc % INC_N) != '0;
    assign fif.NextPC_F     = fif.PCSrc_F ? fif.PCBranch_F : pc_seq;

`ifdef FETCH_PIPE_ELR_EN
    // An exception in the same cycle as a return wins; the return is dropped.
    assign ret_take = fif.ERet_F & ~fif.EProc_F;

    always_ff @(posedge clk) begin
        if (reset) begin
            elr <= '0;
        end else if (fif.EProc_F) begin
            elr <= fif.NextPC_F;
        end
    end
`else
    logic unused_eret;
    assign unused_eret = fif.ERet_F;
    assign ret_take    = 1'b0;
    assign elr         = '0;
`endif

    assign fif.ELR_F = elr;
    assign flush     = fif.EProc_F | ret_take | fif.PCSrc_F;

    always_comb begin
        pc_next = pc_seq;
        if (fif.EProc_F) begin
            pc_next = fif.EVAddr_F;
        end else if (ret_take) begin
            pc_next = elr;
        end else if (fif.PCSrc_F) begin
            pc_next = fif.PCBranch_F;
        end else if (fif.Stall_F) begin
            pc_next = pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= RESET_PC;
            instr_q <= '0;
            pc_d_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            pc <= pc_next;
            // A redirect still captures the slot, but marks it as a bubble.
            if (flush) begin
                instr_q <= fif.imem_data_F;
                pc_d_q  <= pc;
                valid_q <= 1'b0;
            end else if (!fif.Stall_F) begin
                instr_q <= fif.imem_data_F;
                pc_d_q  <= pc;
                valid_q <= ~fif.misalign_F;
            end
        end
    end

    assign fif.instr_D = instr_q;
    assign fif.pc_D    = pc_d_q;
    assign fif.valid_D = valid_q;
endmodule
